// File: rtl/cmd_sched.sv
// cmd_sched: command scheduler between the UART command receiver and cmd_cfg.
// Host commands are buffered in a DEPTH-entry FIFO and offered to cmd_cfg one
// at a time over the cmd_rdy/clr_cmd_rdy handshake; each response is forwarded
// to the UART transmitter. EMER_LAND (0x07) and MTRS_OFF (0x08) flush the
// queue and become its only entry.
// Optional feature macro: CMD_SCHED_WDOG_EN -- link-silence watchdog that
// injects an internal EMER_LAND when the host goes quiet while armed.
module cmd_sched #(
  parameter int DEPTH    = 4,
  parameter bit FAST_SIM = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_rdy,
  input  logic [7:0]               in_cmd,
  input  logic [15:0]              in_data,
  output logic                     in_clr,
  output logic                     cmd_rdy,
  output logic [7:0]               cmd,
  output logic [15:0]              data,
  input  logic                     clr_cmd_rdy,
  input  logic [7:0]               resp_in,
  input  logic                     send_resp_in,
  input  logic                     tx_busy,
  output logic [7:0]               resp,
  output logic                     send_resp,
  output logic [$clog2(DEPTH):0]   q_cnt,
  output logic                     wdog_trip
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0] OP_WDOG = 8'h05;
  localparam logic [7:0] OP_EMER = 8'h07;
  localparam logic [7:0] OP_MTRS = 8'h08;

  // inj marks a command generated inside the scheduler (watchdog EMER_LAND)
  typedef struct packed {
    logic        inj;
    logic [7:0]  cmd;
    logic [15:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RESP, S_FWD} state_t;

  state_t          r_state, w_next;
  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_cnt;
  entry_t          r_iss;
  logic [7:0]      r_resp;

  logic            w_full, w_empty, w_urgent, w_enq, w_pop, w_inject, w_flush;
  entry_t          w_wr_entry;

  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_urgent = (in_cmd == OP_EMER) || (in_cmd == OP_MTRS);
  // urgent host commands bypass the full check so a stalled queue never blocks them
  assign w_enq    = !rst && in_rdy && (w_urgent || !w_full);
  // an urgent command or a watchdog injection replaces the whole queue
  assign w_flush  = (w_enq && w_urgent) || w_inject;

  // Select what gets written: the host command, or the injected EMER_LAND
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_wr_entry = '{inj: 1'b0, cmd: in_cmd, data: in_data};
    if (w_inject) w_wr_entry = '{inj: 1'b1, cmd: OP_EMER, data: 16'h0000};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (w_flush) begin
      // a same-cycle pop has already moved the head into the issue register
      r_rd_ptr <= r_wr_ptr;
      r_wr_ptr <= r_wr_ptr + PW'(1);
      r_cnt    <= CW'(1);
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_cnt <= r_cnt + CW'(w_enq) - CW'(w_pop);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read behind a valid occupancy count.
    if (w_enq || w_inject) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  // Dispatch state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Dispatch next-state and pop decision
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE:     if (clr_cmd_rdy) w_next = S_WAIT_RESP;
      // responses to injected commands are swallowed, never forwarded
      S_WAIT_RESP: if (send_resp_in) w_next = r_iss.inj ? S_IDLE : S_FWD;
      S_FWD:       if (!tx_busy) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Issue register and captured response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss  <= '0;
      r_resp <= '0;
    end else begin
      if (w_pop) r_iss <= r_mem[r_rd_ptr];
      if (r_state == S_WAIT_RESP && send_resp_in && !r_iss.inj) r_resp <= resp_in;
    end
  end

`ifdef CMD_SCHED_WDOG_EN
  localparam int WDOG_W = FAST_SIM ? 9 : 26;

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_armed, r_trip;
  logic              w_leave_issue;

  assign w_leave_issue = (r_state == S_ISSUE) && clr_cmd_rdy;
  // host enqueue in the expiry cycle wins: counter clears, nothing injected
  assign w_inject      = r_armed && (&r_wdog_cnt) && !w_enq;

  // Watchdog arming, silence counter and sticky trip flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_armed    <= 1'b0;
      r_trip     <= 1'b0;
    end else begin
      if (w_leave_issue && r_iss.cmd == OP_WDOG)
        r_armed <= |r_iss.data[8:0];
      else if (w_leave_issue && (r_iss.cmd == OP_EMER || r_iss.cmd == OP_MTRS))
        r_armed <= 1'b0;
      if (w_inject) r_armed <= 1'b0;

      if (w_enq || !r_armed || w_inject) r_wdog_cnt <= '0;
      else                               r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);

      if (w_inject)   r_trip <= 1'b1;
      else if (w_enq) r_trip <= 1'b0;
    end
  end

  assign wdog_trip = r_trip;
`else
  logic w_unused_fast_sim;
  assign w_unused_fast_sim = FAST_SIM;
  assign w_inject          = 1'b0;
  assign wdog_trip         = 1'b0;
`endif

  assign in_clr    = w_enq;
  assign cmd_rdy   = (r_state == S_ISSUE);
  assign cmd       = cmd_rdy ? r_iss.cmd  : 8'h00;
  assign data      = cmd_rdy ? r_iss.data : 16'h0000;
  assign resp      = r_resp;
  assign send_resp = !rst && (r_state == S_FWD) && !tx_busy;
  assign q_cnt     = r_cnt;

endmodule
